alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side controller for the 8-bit ALU datapath. Accepts one opcode plus two operands
//  over a valid/ready handshake and drives each unit's operand buses and one-hot select enables.
//  Each enabled unit outputs its result and every disabled unit outputs 0, so the unit outputs
//  are OR-combined into unit_result. The block waits a programmable settle time, captures that
//  result with zero/carry flags, and returns it over a valid/ready response channel.
// PARAMETERS
//  WIDTH          8   operand/result width
//  OPW            3   opcode width
//  NUM_OPS        6   implemented opcodes 0..NUM_OPS-1 (NUM_OPS <= 2**OPW)
//  SETTLE_CYCLES  1   cycles select is held before capture (>=1)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  cmd_valid   in   1        command offered
//  cmd_ready   out  1        sequencer can accept a command
//  cmd_op      in   OPW      opcode
//  cmd_a       in   WIDTH    operand A
//  cmd_b       in   WIDTH    operand B
//  operand1    out  WIDTH    to all ALU units
//  operand2    out  WIDTH    to all ALU units
//  select      out  NUM_OPS  one-hot unit enables
//  unit_result in   WIDTH    OR of all unit results
//  unit_carry  in   1        carry/borrow from add/sub unit
//  rsp_valid   out  1        response available
//  rsp_ready   in   1        consumer accepts response
//  rsp_result  out  WIDTH    captured result
//  rsp_zero    out  1        rsp_result == 0
//  rsp_carry   out  1        captured unit_carry (0 for logic ops)
//  rsp_err     out  1        opcode >= NUM_OPS
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; cmd_ready=1; select=0; operand1/2=0; rsp_valid=0;
//    rsp_result/zero/carry/err=0; settle counter=0.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/a/b.
//    Legal op -> DRIVE. Illegal op -> RESP with err=1, result=0, zero=0, carry=0.
//  - DRIVE: cmd_ready=0, operand1=a, operand2=b, select=1<<op, held for exactly SETTLE_CYCLES.
//    At the clock edge ending the last cycle, register rsp_result=unit_result,
//    rsp_carry=unit_carry if op is ADD/SUB else 0, and rsp_zero.
//    Then -> RESP. At that same edge, select and operands return to 0.
//  - RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On the handshake -> IDLE and
//    rsp_valid drops the next cycle. cmd_ready stays 0 in RESP (no overlap).
//  - Latency: command accepted at edge N; rsp_valid high from edge N+SETTLE_CYCLES+1.
//    Illegal op: rsp_valid from edge N+1. Max throughput: one op per SETTLE_CYCLES+2 cycles.
//  - select is never multi-hot and is all-zero outside DRIVE, so disabled units output 0.
//  - cmd_* changes while cmd_ready=0 are ignored. rsp_ready held high in IDLE/DRIVE has no effect.
//  - Reset mid-DRIVE or mid-RESP: the op is abandoned, no response is produced, and select
//    clears asynchronously.
// STRUCTURE
//  - Package alu_pkg: WIDTH/OPW defaults; opcode localparams OP_AND=0, OP_OR=1, OP_XOR=2,
//    OP_NOT=3, OP_ADD=4, OP_SUB=5; FSM state encoding ST_IDLE/ST_DRIVE/ST_RESP.
//  - Sub-module alu_sel_decode: combinational opcode -> one-hot select with enable input and
//    illegal flag. Reused by any future ALU issue logic.
//  - Top: FSM, settle counter ($clog2(SETTLE_CYCLES+1) bits), operand/response registers.
// TESTING
//  1. Reset, then OP_AND a=8'hF0 b=8'h3C with the bench AND model.
//     -> select=6'b000001 for 1 cycle; rsp_result=8'h30, zero=0, carry=0; rsp_valid at N+2.
//  2. OP_ADD a=8'hFF b=8'h01 -> rsp_result=8'h00, rsp_zero=1, rsp_carry=1.
//  3. cmd_op=3'd7 (illegal) -> select never asserted; rsp_valid at N+1 with rsp_err=1 and
//     rsp_result=0.
//  4. rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0 throughout.
//     A second cmd_valid is not accepted until the cycle after the response handshake.
//  5. SETTLE_CYCLES=3, OP_XOR a=8'hAA b=8'h55 -> select held 3 cycles, rsp_result=8'hFF,
//     back-to-back commands spaced 5 cycles.
//  6. Assert rst_n=0 in the 2nd DRIVE cycle -> select and operands 0 immediately, no
//     rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer and its select decoder.
package alu_pkg;

  localparam int ALU_WIDTH   = 8;
  localparam int ALU_OPW     = 3;
  localparam int ALU_NUM_OPS = 6;

  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 2;
  localparam int OP_NOT = 3;
  localparam int OP_ADD = 4;
  localparam int OP_SUB = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Only the add/sub unit produces a meaningful carry/borrow.
  function automatic logic op_has_carry(input int op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-unit buses of the sequencer; slave is the sequencer side.
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OPW     = ALU_OPW,
  parameter int NUM_OPS = ALU_NUM_OPS
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [OPW-1:0]     cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [WIDTH-1:0]   operand1;
  logic [WIDTH-1:0]   operand2;
  logic [NUM_OPS-1:0] select;
  logic [WIDTH-1:0]   unit_result;
  logic               unit_carry;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_carry;
  logic               rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, unit_result, unit_carry, rsp_ready,
    output cmd_ready, operand1, operand2, select, rsp_valid, rsp_result, rsp_zero,
           rsp_carry, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, unit_result, unit_carry, rsp_ready,
    input  cmd_ready, operand1, operand2, select, rsp_valid, rsp_result, rsp_zero,
           rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_sel_decode.sv
// Opcode to one-hot unit select; select stays all-zero when disabled or the opcode is unimplemented.
module alu_sel_decode #(
  parameter int OPW     = 3,
  parameter int NUM_OPS = 6
) (
  input  logic               en,
  input  logic [OPW-1:0]     op,
  output logic [NUM_OPS-1:0] select,
  output logic               illegal
);

  always_comb begin
    illegal = (32'(op) >= NUM_OPS);
    select  = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      select[i] = en && (op == OPW'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time: drives operands/select for a settle window,
// captures the OR-combined unit result with flags and returns it on the response channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int OPW           = ALU_OPW,
  parameter int NUM_OPS       = ALU_NUM_OPS,
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int             CW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(SETTLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [OPW-1:0]       op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q, carry_q, err_q;

  logic                 accept, capture;
  logic                 dec_en, dec_illegal;
  logic [OPW-1:0]       dec_op;
  logic [NUM_OPS-1:0]   dec_sel;

  // In IDLE the decoder classifies the offered opcode; in DRIVE it decodes the latched one.
  assign dec_en = (state == ST_DRIVE);
  assign dec_op = (state == ST_IDLE) ? bus.cmd_op : op_q;

  alu_sel_decode #(.OPW(OPW), .NUM_OPS(NUM_OPS)) u_sel_decode (
    .en      (dec_en),
    .op      (dec_op),
    .select  (dec_sel),
    .illegal (dec_illegal)
  );

  // Outputs toward the units are gated by state so async reset clears them at once.
  assign bus.select     = dec_sel;
  assign bus.operand1   = dec_en ? a_q : '0;
  assign bus.operand2   = dec_en ? b_q : '0;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = dec_illegal ? ST_RESP : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt == LAST) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.cmd_op;
        a_q  <= bus.cmd_a;
        b_q  <= bus.cmd_b;
        cnt  <= '0;
        if (dec_illegal) begin
          result_q <= '0;
          zero_q   <= 1'b0;
          carry_q  <= 1'b0;
          err_q    <= 1'b1;
        end
      end
      if (dec_en && !capture) cnt <= cnt + 1'b1;
      if (capture) begin
        result_q <= bus.unit_result;
        zero_q   <= (bus.unit_result == '0);
        carry_q  <= op_has_carry(int'(op_q)) & bus.unit_carry;
        err_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) driving a behavioural ALU,
// with queued expected responses checked by per-instance monitors.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;
  } rsp_t;

  logic clk;
  logic rst0_n, rst1_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t e0, e1;

  alu_op_sequencer_if #(.WIDTH(8), .OPW(3), .NUM_OPS(6)) bus0 ();
  alu_op_sequencer_if #(.WIDTH(8), .OPW(3), .NUM_OPS(6)) bus1 ();

  alu_op_sequencer #(.WIDTH(8), .OPW(3), .NUM_OPS(6), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0));
  alu_op_sequencer #(.WIDTH(8), .OPW(3), .NUM_OPS(6), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU units: each enabled unit contributes, disabled units give 0.
  function automatic logic [8:0] alu_model(input logic [5:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] r;
    logic       c;
    logic [8:0] s;
    r = '0;
    c = 1'b0;
    if (sel[OP_AND]) r = r | (a & b);
    if (sel[OP_OR])  r = r | (a | b);
    if (sel[OP_XOR]) r = r | (a ^ b);
    if (sel[OP_NOT]) r = r | ~a;
    if (sel[OP_ADD]) begin s = {1'b0, a} + {1'b0, b}; r = r | s[7:0]; c = s[8]; end
    if (sel[OP_SUB]) begin s = {1'b0, a} - {1'b0, b}; r = r | s[7:0]; c = s[8]; end
    return {c, r};
  endfunction

  always_comb {bus0.unit_carry, bus0.unit_result} = alu_model(bus0.select, bus0.operand1, bus0.operand2);
  always_comb {bus1.unit_carry, bus1.unit_result} = alu_model(bus1.select, bus1.operand1, bus1.operand2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.rsp_valid && bus0.rsp_ready) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp0_unexpected: got result 0x%0h, expected no response", bus0.rsp_result);
      end else begin
        e0 = q0.pop_front();
        check("rsp0", 32'({bus0.rsp_result, bus0.rsp_zero, bus0.rsp_carry, bus0.rsp_err}), 32'(e0));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rsp_valid && bus1.rsp_ready) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp1_unexpected: got result 0x%0h, expected no response", bus1.rsp_result);
      end else begin
        e1 = q1.pop_front();
        check("rsp1", 32'({bus1.rsp_result, bus1.rsp_zero, bus1.rsp_carry, bus1.rsp_err}), 32'(e1));
      end
    end
  end

  task automatic send0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b1; bus0.cmd_op = op; bus0.cmd_a = a; bus0.cmd_b = b;
    t = 0;
    @(negedge clk);
    while (!bus0.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus0.cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send0_timeout: got cmd_ready 0, expected 1");
    end
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic send1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b1; bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b;
    t = 0;
    @(negedge clk);
    while (!bus1.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus1.cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send1_timeout: got cmd_ready 0, expected 1");
    end
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int t = 0;
    @(negedge clk);
    while (!(bus0.cmd_ready && !bus0.rsp_valid) && t < 50) begin @(negedge clk); t++; end
    if (!bus0.cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL idle0_timeout: got cmd_ready 0, expected 1");
    end
  endtask

  task automatic wait_idle1();
    int t = 0;
    @(negedge clk);
    while (!(bus1.cmd_ready && !bus1.rsp_valid) && t < 50) begin @(negedge clk); t++; end
    if (!bus1.cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL idle1_timeout: got cmd_ready 0, expected 1");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst0_n = 1'b1; rst1_n = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = '0; bus0.cmd_a = '0; bus0.cmd_b = '0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.rsp_ready = 1'b0;
    #1 rst0_n = 1'b0; rst1_n = 1'b0;
    #2;
    check("reset_cmd_ready", 32'(bus0.cmd_ready), 1);
    check("reset_select",    32'(bus0.select), 0);
    check("reset_operand1",  32'(bus0.operand1), 0);
    check("reset_rsp_valid", 32'(bus0.rsp_valid), 0);
    check("reset_rsp",       32'({bus0.rsp_result, bus0.rsp_zero, bus0.rsp_carry, bus0.rsp_err}), 0);
    @(posedge clk); #1;
    rst0_n = 1'b1; rst1_n = 1'b1;
    bus0.rsp_ready = 1'b1; bus1.rsp_ready = 1'b1;

    // AND with single-cycle select and response two edges after acceptance
    q0.push_back('{result: 8'h30, zero: 1'b0, carry: 1'b0, err: 1'b0});
    send0(3'(OP_AND), 8'hF0, 8'h3C);
    @(negedge clk);
    check("and_select",    32'(bus0.select), 'b000001);
    check("and_operand1",  32'(bus0.operand1), 'hF0);
    check("and_operand2",  32'(bus0.operand2), 'h3C);
    check("and_valid_n1",  32'(bus0.rsp_valid), 0);
    check("and_ready_busy", 32'(bus0.cmd_ready), 0);
    @(negedge clk);
    check("and_select_off", 32'(bus0.select), 0);
    check("and_operand_off", 32'(bus0.operand1), 0);
    check("and_valid_n2",  32'(bus0.rsp_valid), 1);
    @(negedge clk);
    check("and_valid_drop", 32'(bus0.rsp_valid), 0);
    check("and_ready_back", 32'(bus0.cmd_ready), 1);

    // ADD wrapping to zero with carry out
    q0.push_back('{result: 8'h00, zero: 1'b1, carry: 1'b1, err: 1'b0});
    send0(3'(OP_ADD), 8'hFF, 8'h01);
    wait_idle0();

    // Illegal opcode answers on the next edge with err and no select
    q0.push_back('{result: 8'h00, zero: 1'b0, carry: 1'b0, err: 1'b1});
    send0(3'd7, 8'h12, 8'h34);
    @(negedge clk);
    check("ill_valid",  32'(bus0.rsp_valid), 1);
    check("ill_err",    32'(bus0.rsp_err), 1);
    check("ill_select", 32'(bus0.select), 0);
    check("ill_result", 32'(bus0.rsp_result), 0);
    wait_idle0();

    // NOT of all-ones: zero result, carry masked for logic ops
    q0.push_back('{result: 8'h00, zero: 1'b1, carry: 1'b0, err: 1'b0});
    send0(3'(OP_NOT), 8'hFF, 8'h00);
    wait_idle0();

    // Response back-pressure with a second command pending
    bus0.rsp_ready = 1'b0;
    q0.push_back('{result: 8'h33, zero: 1'b0, carry: 1'b0, err: 1'b0});
    send0(3'(OP_OR), 8'h12, 8'h21);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", 32'(bus0.rsp_valid), 1);
    @(posedge clk); #1;
    q0.push_back('{result: 8'hFE, zero: 1'b0, carry: 1'b1, err: 1'b0});
    bus0.cmd_valid = 1'b1; bus0.cmd_op = 3'(OP_SUB); bus0.cmd_a = 8'h05; bus0.cmd_b = 8'h07;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus0.rsp_valid), 1);
      check("bp_hold_rsp",   32'({bus0.rsp_result, bus0.rsp_zero, bus0.rsp_carry, bus0.rsp_err}),
            32'({8'h33, 3'b000}));
      check("bp_cmd_ready",  32'(bus0.cmd_ready), 0);
    end
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_cmd_ready", 32'(bus0.cmd_ready), 0);
    @(negedge clk);
    check("bp_after_valid", 32'(bus0.rsp_valid), 0);
    check("bp_after_ready", 32'(bus0.cmd_ready), 1);
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_sub_select", 32'(bus0.select), 'b100000);
    check("bp_sub_busy",   32'(bus0.cmd_ready), 0);
    wait_idle0();

    // Settle of 3 cycles with a back-to-back command offered immediately
    q1.push_back('{result: 8'hFF, zero: 1'b0, carry: 1'b0, err: 1'b0});
    send1(3'(OP_XOR), 8'hAA, 8'h55);
    q1.push_back('{result: 8'h00, zero: 1'b1, carry: 1'b1, err: 1'b0});
    bus1.cmd_valid = 1'b1; bus1.cmd_op = 3'(OP_ADD); bus1.cmd_a = 8'h80; bus1.cmd_b = 8'h80;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("xor_select",    32'(bus1.select), 'b000100);
      check("xor_valid_low", 32'(bus1.rsp_valid), 0);
      check("xor_busy",      32'(bus1.cmd_ready), 0);
    end
    @(negedge clk);
    check("xor_select_off", 32'(bus1.select), 0);
    check("xor_valid",      32'(bus1.rsp_valid), 1);
    check("xor_busy_resp",  32'(bus1.cmd_ready), 0);
    @(negedge clk);
    check("b2b_ready_at_5", 32'(bus1.cmd_ready), 1);
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_add_select", 32'(bus1.select), 'b010000);
    wait_idle1();

    // Reset during the second DRIVE cycle abandons the operation
    send1(3'(OP_OR), 8'h01, 8'h02);
    @(negedge clk);
    check("rst_pre_select", 32'(bus1.select), 'b000010);
    @(negedge clk);
    #1 rst1_n = 1'b0;
    #1;
    check("rst_select",    32'(bus1.select), 0);
    check("rst_operands",  32'({bus1.operand1, bus1.operand2}), 0);
    check("rst_cmd_ready", 32'(bus1.cmd_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst1_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus1.rsp_valid) seen = 1'b1;
    end
    check("rst_no_response", 32'(seen), 0);
    check("rst_ready_after", 32'(bus1.cmd_ready), 1);

    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
